// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared types and constants for the instruction-fetch controller
package ifetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } qentry_t;

  localparam int QDEPTH = 2;

  function automatic logic is_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/ifetch_if.sv
// rtl/ifetch_if.sv - fetch-to-decode valid/ready handshake bundle
interface ifetch_if;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  modport master (output out_valid, output out_instr, output out_pc, input out_ready);
  modport slave  (input out_valid, input out_instr, input out_pc, output out_ready);
endinterface

// File: rtl/ifetch_fetch_queue.sv
// rtl/ifetch_fetch_queue.sv - 2-entry FIFO of fetched {instr, pc}; flush beats push
module fetch_queue
  import ifetch_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  logic    pop,
  input  logic    flush,
  input  qentry_t din,
  output qentry_t head,
  output logic    full,
  output logic    empty
);

  qentry_t    mem [QDEPTH];
  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] count;

  // Storage, pointers and occupancy; a flush discards everything including a same-cycle push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == 2'(QDEPTH));
  assign empty = (count == 2'd0);

endmodule

// File: rtl/ifetch_ctrl.sv
// rtl/ifetch_ctrl.sv - fetch FSM, program counter, range/alignment checks and fault capture
module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic [31:0]   imem_addr,
  input  logic [31:0]   imem_rdata,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  ifetch_if.master      dec,
  output logic          running,
  output logic          fault,
  output logic [31:0]   fault_pc
);

  localparam logic [31:0] PC_LIMIT = 32'(4 * IMEM_WORDS);

  state_t      state, state_nx;
  logic [31:0] pc;
  logic        pop, can_accept, in_range;
  logic        redir_ok, redir_bad;
  logic        push, flush, fetch_fault;
  logic        full, empty;
  qentry_t     din, head;

  assign pop        = dec.out_valid && dec.out_ready;
  assign can_accept = !full || pop;
  assign in_range   = pc < PC_LIMIT;
  assign redir_ok   = redirect_valid && is_aligned(redirect_pc) && (state != ST_HALT);
  assign redir_bad  = redirect_valid && !is_aligned(redirect_pc) && (state != ST_HALT);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next state: a misaligned redirect or an out-of-range fetch halts until reset.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (redir_bad)  state_nx = ST_HALT;
        else if (start) state_nx = ST_RUN;
      end
      ST_RUN: begin
        if (redir_bad) state_nx = ST_HALT;
        else if (!redirect_valid && can_accept && !in_range) state_nx = ST_HALT;
      end
      ST_HALT: state_nx = ST_HALT;
      default: state_nx = ST_IDLE;
    endcase
  end

  // FSM outputs: fetch only in RUN with room, never in a redirect cycle.
  always_comb begin
    push        = 1'b0;
    fetch_fault = 1'b0;
    flush       = redirect_valid && (state != ST_HALT);
    if (state == ST_RUN && !redirect_valid && can_accept) begin
      push        = in_range;
      fetch_fault = !in_range;
    end
  end

  // Program counter and sticky fault capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      fault    <= 1'b0;
      fault_pc <= 32'h0;
    end else begin
      if (redir_ok)  pc <= redirect_pc;
      else if (push) pc <= pc + 32'd4;
      if (redir_bad) begin
        fault    <= 1'b1;
        fault_pc <= redirect_pc;
      end else if (fetch_fault) begin
        fault    <= 1'b1;
        fault_pc <= pc;
      end
    end
  end

  assign din.instr = imem_rdata;
  assign din.pc    = pc;

  fetch_queue u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (din),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  assign dec.out_valid = !empty;
  assign dec.out_instr = head.instr;
  assign dec.out_pc    = head.pc;
  assign imem_addr     = pc;
  assign running       = (state == ST_RUN);

endmodule
